// File: rtl/output_ram_streamer_if.sv
// Bus between the output RAM streamer and its RAM / control / downstream consumer.
// master = streamer side, slave = environment side.
interface output_ram_streamer_if #(
  parameter int ADD_SIZE  = 11,
  parameter int DATA_SIZE = 32
);
  logic                 start;
  logic [ADD_SIZE-1:0]  base_address;
  logic [ADD_SIZE:0]    length;
  logic                 read_en;
  logic [ADD_SIZE-1:0]  read_address;
  logic [DATA_SIZE-1:0] ram_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] dataOut;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, base_address, length, ram_data, out_ready,
    output read_en, read_address, out_valid, dataOut, busy, done
  );

  modport slave (
    output start, base_address, length, ram_data, out_ready,
    input  read_en, read_address, out_valid, dataOut, busy, done
  );
endinterface

// File: rtl/output_ram_streamer.sv
// Drains a contiguous block of the output RAM into a valid/ready stream,
// hiding the 1-cycle RAM read latency behind a 2-entry FIFO.
module output_ram_streamer #(
  parameter int ADD_SIZE  = 11,
  parameter int DATA_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output_ram_streamer_if.master  bus_io
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADD_SIZE:0]   CNT_ZERO  = {(ADD_SIZE+1){1'b0}};
  localparam logic [ADD_SIZE:0]   CNT_ONE   = {{ADD_SIZE{1'b0}}, 1'b1};
  localparam logic [ADD_SIZE-1:0] ADDR_ONE  = {{(ADD_SIZE-1){1'b0}}, 1'b1};
  localparam logic [ADD_SIZE-1:0] ADDR_ZERO = {ADD_SIZE{1'b0}};
  localparam logic [DATA_SIZE-1:0] DATA_ZERO = {DATA_SIZE{1'b0}};

  state_t               state_q, state_d;
  logic [ADD_SIZE:0]    length_q, length_d;
  logic [ADD_SIZE:0]    issued_q, issued_d;
  logic [ADD_SIZE:0]    sent_q, sent_d;
  logic [ADD_SIZE-1:0]  addr_q, addr_d;
  logic                 inflight_q, inflight_d;
  logic [DATA_SIZE-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic                 out_valid_s, pop_s, push_s, rd_en_s;
  logic [2:0]           occ_s;

  // Slots committed after this edge: buffered + returning - leaving. A new
  // read lands one cycle later, so it may issue only while this is below 2.
  assign out_valid_s = (count_q != 2'd0);
  assign pop_s       = out_valid_s & bus_io.out_ready;
  assign push_s      = inflight_q;
  assign occ_s       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign rd_en_s     = (state_q == S_READ) && (issued_q < length_q) && (occ_s < 3'd2);

  assign bus_io.read_en      = rd_en_s;
  assign bus_io.read_address = addr_q;
  assign bus_io.out_valid    = out_valid_s;
  assign bus_io.dataOut      = rd_ptr_q ? mem1_q : mem0_q;
  assign bus_io.busy         = busy_q;
  assign bus_io.done         = done_q;

  // Next-state logic for the FSM, counters and output FIFO.
  always_comb begin
    state_d    = state_q;
    length_d   = length_q;
    issued_d   = issued_q;
    addr_d     = addr_q;
    sent_d     = pop_s ? (sent_q + CNT_ONE) : sent_q;
    inflight_d = rd_en_s;
    mem0_d     = mem0_q;
    mem1_d     = mem1_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + {1'b0, push_s} - {1'b0, pop_s};

    if (push_s) begin
      if (wr_ptr_q) begin
        mem1_d = bus_io.ram_data;
      end else begin
        mem0_d = bus_io.ram_data;
      end
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus_io.start) begin
          length_d = bus_io.length;
          addr_d   = bus_io.base_address;
          issued_d = CNT_ZERO;
          sent_d   = CNT_ZERO;
          state_d  = (bus_io.length == CNT_ZERO) ? S_DONE : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (rd_en_s) begin
          issued_d = issued_q + CNT_ONE;
          addr_d   = addr_q + ADDR_ONE;
          state_d  = ((issued_q + CNT_ONE) == length_q) ? S_DRAIN : S_READ;
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if (pop_s && ((sent_q + CNT_ONE) == length_q)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State register; reset drops any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      length_q   <= CNT_ZERO;
      issued_q   <= CNT_ZERO;
      sent_q     <= CNT_ZERO;
      addr_q     <= ADDR_ZERO;
      inflight_q <= 1'b0;
      mem0_q     <= DATA_ZERO;
      mem1_q     <= DATA_ZERO;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      length_q   <= length_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      mem0_q     <= mem0_d;
      mem1_q     <= mem1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_output_ram_streamer.sv
// Directed self-checking bench for output_ram_streamer with a behavioural
// RAM that returns data one cycle after read_en.
module tb_output_ram_streamer;
  localparam int AW = 11;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  output_ram_streamer_if #(.ADD_SIZE(AW), .DATA_SIZE(DW)) bus ();
  output_ram_streamer #(.ADD_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  logic [DW-1:0] ram [0:2047];
  logic [DW-1:0] ram_q = '0;
  int vectors = 0;
  int miscompares = 0;

  assign bus.ram_data = ram_q;
  always @(posedge clk) if (bus.read_en) ram_q <= ram[bus.read_address];

  task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_address = b; bus.length = l;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (bus.read_en !== 1'b0) begin miscompares++; $display("FAIL reset_read_en got %b want 0", bus.read_en); end
    vectors++; if (bus.read_address !== 11'd0) begin miscompares++; $display("FAIL reset_read_address got %0d want 0", bus.read_address); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.dataOut !== 32'd0) begin miscompares++; $display("FAIL reset_dataOut got %h want 0", bus.dataOut); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_d [3];
    int first_valid = -1, nwords = 0, nreads = 0, ndone = 0, done_cyc = -1;
    exp_d[0] = 32'h0000_0000; exp_d[1] = 32'h0000_0124; exp_d[2] = 32'h0000_0165;
    ram[0] = 32'h0000_0000; ram[1] = 32'h0000_0124; ram[2] = 32'h0000_0165;
    bus.out_ready = 1'b1;
    start_xfer(11'd0, 12'd3);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (bus.read_en) begin
        vectors++; if (bus.read_address !== 11'(nreads)) begin miscompares++; $display("FAIL basic_addr got %0d want %0d", bus.read_address, nreads); end
        nreads++;
      end
      if (bus.out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (nwords < 3) begin
          vectors++; if (bus.dataOut !== exp_d[nwords]) begin miscompares++; $display("FAIL basic_data[%0d] got %h want %h", nwords, bus.dataOut, exp_d[nwords]); end
        end
        vectors++; if (cyc !== first_valid + nwords) begin miscompares++; $display("FAIL basic_gapfree got cycle %0d want %0d", cyc, first_valid + nwords); end
        nwords++;
      end
      if (bus.done) begin ndone++; done_cyc = cyc; end
    end
    vectors++; if (first_valid !== 3) begin miscompares++; $display("FAIL basic_first_valid got %0d want 3", first_valid); end
    vectors++; if (nwords !== 3) begin miscompares++; $display("FAIL basic_nwords got %0d want 3", nwords); end
    vectors++; if (nreads !== 3) begin miscompares++; $display("FAIL basic_nreads got %0d want 3", nreads); end
    vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL basic_ndone got %0d want 1", ndone); end
    vectors++; if (done_cyc !== 6) begin miscompares++; $display("FAIL basic_done_cycle got %0d want 6", done_cyc); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end got %b want 0", bus.busy); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_d [3];
    logic pat [4];
    logic [DW-1:0] prev_data = '0;
    logic prev_stall = 1'b0, pop;
    int outst = 0, nwords = 0, nreads = 0, ndone = 0, done_cyc = -1, third_read = -1;
    exp_d[0] = 32'h0000_0000; exp_d[1] = 32'h0000_0124; exp_d[2] = 32'h0000_0165;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    start_xfer(11'd0, 12'd3);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      bus.out_ready = pat[(cyc - 1) % 4];
      @(negedge clk);
      pop = bus.out_valid & bus.out_ready;
      if (prev_stall) begin
        vectors++; if (bus.out_valid !== 1'b1 || bus.dataOut !== prev_data) begin miscompares++; $display("FAIL bp_stable got v=%b d=%h want v=1 d=%h", bus.out_valid, bus.dataOut, prev_data); end
      end
      if (bus.read_en) begin
        vectors++; if (outst - int'(pop) >= 2) begin miscompares++; $display("FAIL bp_read_limit got read_en=1 with %0d committed want <2", outst - int'(pop)); end
        nreads++;
        if (nreads == 3) third_read = cyc;
      end
      if (pop) begin
        if (nwords < 3) begin
          vectors++; if (bus.dataOut !== exp_d[nwords]) begin miscompares++; $display("FAIL bp_data[%0d] got %h want %h", nwords, bus.dataOut, exp_d[nwords]); end
        end
        nwords++;
      end
      if (bus.done) begin ndone++; done_cyc = cyc; end
      outst = outst + int'(bus.read_en) - int'(pop);
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data = bus.dataOut;
      @(posedge clk); #1;
    end
    vectors++; if (nwords !== 3) begin miscompares++; $display("FAIL bp_nwords got %0d want 3", nwords); end
    vectors++; if (nreads !== 3) begin miscompares++; $display("FAIL bp_nreads got %0d want 3", nreads); end
    vectors++; if (third_read !== 4) begin miscompares++; $display("FAIL bp_third_read_cycle got %0d want 4", third_read); end
    vectors++; if (ndone !== 1 || done_cyc !== 9) begin miscompares++; $display("FAIL bp_done got n=%0d cyc=%0d want n=1 cyc=9", ndone, done_cyc); end
  endtask

  task automatic test_zero_length();
    bus.out_ready = 1'b1;
    start_xfer(11'd5, 12'd0);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      vectors++; if (bus.read_en !== 1'b0 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_no_activity cyc %0d got re=%b v=%b want 0 0", cyc, bus.read_en, bus.out_valid); end
      vectors++; if (bus.done !== (cyc == 1)) begin miscompares++; $display("FAIL zero_done cyc %0d got %b want %b", cyc, bus.done, (cyc == 1)); end
      vectors++; if (bus.busy !== (cyc == 1)) begin miscompares++; $display("FAIL zero_busy cyc %0d got %b want %b", cyc, bus.busy, (cyc == 1)); end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4];
    logic [DW-1:0] exp_d [4];
    int nwords = 0, nreads = 0, ndone = 0;
    exp_a[0] = 11'd2046; exp_a[1] = 11'd2047; exp_a[2] = 11'd0; exp_a[3] = 11'd1;
    exp_d[0] = 32'hDEAD_0001; exp_d[1] = 32'hBEEF_0002; exp_d[2] = 32'h1111_2222; exp_d[3] = 32'h3333_4444;
    ram[2046] = 32'hDEAD_0001; ram[2047] = 32'hBEEF_0002; ram[0] = 32'h1111_2222; ram[1] = 32'h3333_4444;
    bus.out_ready = 1'b1;
    start_xfer(11'd2046, 12'd4);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (bus.read_en) begin
        if (nreads < 4) begin
          vectors++; if (bus.read_address !== exp_a[nreads]) begin miscompares++; $display("FAIL wrap_addr[%0d] got %0d want %0d", nreads, bus.read_address, exp_a[nreads]); end
        end
        nreads++;
      end
      if (bus.out_valid) begin
        if (nwords < 4) begin
          vectors++; if (bus.dataOut !== exp_d[nwords]) begin miscompares++; $display("FAIL wrap_data[%0d] got %h want %h", nwords, bus.dataOut, exp_d[nwords]); end
        end
        nwords++;
      end
      if (bus.done) ndone++;
    end
    vectors++; if (nreads !== 4 || nwords !== 4 || ndone !== 1) begin miscompares++; $display("FAIL wrap_counts got r=%0d w=%0d d=%0d want 4 4 1", nreads, nwords, ndone); end
  endtask

  task automatic test_midburst();
    logic [DW-1:0] exp_d [3];
    int nwords = 0, nreads = 0, ndone = 0;
    exp_d[0] = 32'hA000_000A; exp_d[1] = 32'hA000_000B; exp_d[2] = 32'hA000_000C;
    ram[10] = 32'hA000_000A; ram[11] = 32'hA000_000B; ram[12] = 32'hA000_000C;
    ram[30] = 32'hC0DE_0030; ram[31] = 32'hC0DE_0031;
    // Stalled transfer with a second start pulsed while busy.
    bus.out_ready = 1'b0;
    start_xfer(11'd10, 12'd3);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      if (cyc == 2) begin bus.start = 1'b1; bus.base_address = 11'd20; bus.length = 12'd1; end
      if (cyc == 3) bus.start = 1'b0;
      if (cyc == 7) bus.out_ready = 1'b1;
      @(negedge clk);
      if (bus.read_en) begin
        vectors++; if (bus.read_address !== 11'(10 + nreads)) begin miscompares++; $display("FAIL busy_start_addr got %0d want %0d", bus.read_address, 10 + nreads); end
        nreads++;
      end
      if (cyc == 6) begin
        vectors++; if (nreads !== 2 || bus.busy !== 1'b1 || bus.dataOut !== exp_d[0]) begin miscompares++; $display("FAIL stall_state got r=%0d busy=%b d=%h want 2 1 %h", nreads, bus.busy, bus.dataOut, exp_d[0]); end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (nwords < 3) begin
          vectors++; if (bus.dataOut !== exp_d[nwords]) begin miscompares++; $display("FAIL busy_start_data[%0d] got %h want %h", nwords, bus.dataOut, exp_d[nwords]); end
        end
        nwords++;
      end
      if (bus.done) ndone++;
      @(posedge clk); #1;
    end
    vectors++; if (nreads !== 3 || nwords !== 3 || ndone !== 1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL busy_start_counts got r=%0d w=%0d d=%0d busy=%b want 3 3 1 0", nreads, nwords, ndone, bus.busy); end

    // Reset while reads are outstanding.
    bus.out_ready = 1'b0;
    start_xfer(11'd10, 12'd3);
    repeat (3) @(negedge clk);
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_valid got %b want 1", bus.out_valid); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.read_en !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_ctrl got v=%b re=%b busy=%b want 0 0 0", bus.out_valid, bus.read_en, bus.busy); end
    vectors++; if (bus.dataOut !== 32'd0 || bus.read_address !== 11'd0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL midrst_data got d=%h a=%0d done=%b want 0 0 0", bus.dataOut, bus.read_address, bus.done); end
    @(posedge clk); #1; rst = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL postrst_valid got %b want 0", bus.out_valid); end

    nwords = 0; ndone = 0;
    start_xfer(11'd30, 12'd2);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        vectors++; if (bus.dataOut !== (nwords == 0 ? 32'hC0DE_0030 : 32'hC0DE_0031)) begin miscompares++; $display("FAIL postrst_data[%0d] got %h", nwords, bus.dataOut); end
        nwords++;
      end
      if (bus.done) ndone++;
    end
    vectors++; if (nwords !== 2 || ndone !== 1) begin miscompares++; $display("FAIL postrst_counts got w=%0d d=%0d want 2 1", nwords, ndone); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base_address = 11'd0;
    bus.length = 12'd0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2048; i++) ram[i] = 32'(i) ^ 32'h5A5A_0000;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_length();
    test_wrap();
    test_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
